// File: rtl/qpsk_pkg.sv
// Shared types and widths for the QPSK receive path: arbiter FSM states,
// IQ/phase word widths and an index-width helper.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int PHASE_W   = 32;
  localparam int IQ_PAIR_W = 64;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_engine_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: finds the first asserted request
// starting one position after the last grant, wrapping at NUM_REQ.
module rr_priority_pick
  import qpsk_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      last_i,
  output logic [GW-1:0]      pick_o,
  output logic               any_o
);

  localparam int SW = GW + 1;

  logic [GW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_vld;

  // Candidate gi is the requester gi+1 places after last_i; one subtract
  // suffices because last_i + gi + 1 never reaches 2*NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SW-1:0] sum;
      assign sum = {1'b0, last_i} + SW'(gi + 1);
      assign cand_idx[gi] = (sum >= SW'(NUM_REQ)) ? GW'(sum - SW'(NUM_REQ))
                                                   : sum[GW-1:0];
      assign cand_vld[gi] = req_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        pick_o = cand_idx[k];
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_engine_arbiter.sv
// Shares one get_phase (atan2) engine between NUM_REQ requesters: round-robin
// grant, one transaction in flight, watchdog-forced error response.
module phase_engine_arbiter
  import qpsk_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TDATA_WIDTH    = IQ_PAIR_W,
  parameter int PHASE_WIDTH    = PHASE_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           s00_axis_aclk,
  input  logic                           s00_axis_areset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0] req_tdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [PHASE_WIDTH-1:0]         rsp_phase,
  output logic                           rsp_error,
  output logic [TDATA_WIDTH-1:0]         phase_tdata,
  output logic                           get_phase_s00_valid,
  input  logic                           get_phase_s00_ready,
  input  logic                           get_phase_m00_valid,
  input  logic [PHASE_WIDTH-1:0]         phase,
  output logic                           busy,
  output logic [15:0]                    timeout_count,
  output logic                           stray_rsp
);

  localparam int GW  = idx_w(NUM_REQ);
  localparam int TMW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMW-1:0] TIMER_LAST = TMW'(TIMEOUT_CYCLES - 1);

  arb_state_t               state_q;
  logic [GW-1:0]            grant_q;
  logic [GW-1:0]            last_grant_q;
  logic [TDATA_WIDTH-1:0]   phase_tdata_q;
  logic                     s00_valid_q;
  logic [TMW-1:0]           timer_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [PHASE_WIDTH-1:0]   rsp_phase_q;
  logic                     rsp_error_q;
  logic [15:0]              timeout_count_q;
  logic                     stray_q;

  logic [TDATA_WIDTH-1:0]   req_data [NUM_REQ];
  logic [GW-1:0]            pick;
  logic                     pick_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_data[gi]  = req_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
      assign req_ready[gi] = (state_q == IDLE) && pick_any &&
                             (pick == GW'(gi)) && req_valid[gi];
    end
  endgenerate

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      last_grant_q    <= GW'(NUM_REQ - 1);
      phase_tdata_q   <= '0;
      s00_valid_q     <= 1'b0;
      timer_q         <= '0;
      rsp_valid_q     <= '0;
      rsp_phase_q     <= '0;
      rsp_error_q     <= 1'b0;
      timeout_count_q <= '0;
      stray_q         <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (get_phase_m00_valid && (state_q != WAIT)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q       <= pick;
            phase_tdata_q <= req_data[pick];
            s00_valid_q   <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (get_phase_s00_ready) begin
            s00_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // A real result beats the watchdog when both land in the same cycle.
          if (get_phase_m00_valid) begin
            rsp_phase_q <= phase;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= RESP;
          end else if (timer_q == TIMER_LAST) begin
            rsp_phase_q <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            if (timeout_count_q != 16'hFFFF) begin
              timeout_count_q <= timeout_count_q + 16'd1;
            end
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + TMW'(1);
          end
        end
        RESP: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid           = rsp_valid_q;
  assign rsp_phase           = rsp_phase_q;
  assign rsp_error           = rsp_error_q;
  assign phase_tdata         = phase_tdata_q;
  assign get_phase_s00_valid = s00_valid_q;
  assign busy                = (state_q != IDLE);
  assign timeout_count       = timeout_count_q;
  assign stray_rsp           = stray_q;

endmodule

// File: tb/tb_phase_engine_arbiter.sv
// Directed bench for phase_engine_arbiter with a behavioural get_phase engine
// and a response scoreboard.
module tb_phase_engine_arbiter;

  localparam int NR = 2;
  localparam int TW = 64;
  localparam int PW = 32;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*TW-1:0] req_tdata;
  logic [NR-1:0]    rsp_valid;
  logic [PW-1:0]    rsp_phase;
  logic             rsp_error;
  logic [TW-1:0]    phase_tdata;
  logic             s00_valid;
  logic             s00_ready;
  logic             m00_valid;
  logic [PW-1:0]    phase;
  logic             busy;
  logic [15:0]      timeout_count;
  logic             stray_rsp;

  always #5 clk = ~clk;

  phase_engine_arbiter #(
    .NUM_REQ        (NR),
    .TDATA_WIDTH    (TW),
    .PHASE_WIDTH    (PW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .s00_axis_aclk       (clk),
    .s00_axis_areset     (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_tdata           (req_tdata),
    .rsp_valid           (rsp_valid),
    .rsp_phase           (rsp_phase),
    .rsp_error           (rsp_error),
    .phase_tdata         (phase_tdata),
    .get_phase_s00_valid (s00_valid),
    .get_phase_s00_ready (s00_ready),
    .get_phase_m00_valid (m00_valid),
    .phase               (phase),
    .busy                (busy),
    .timeout_count       (timeout_count),
    .stray_rsp           (stray_rsp)
  );

  typedef struct {
    logic [NR-1:0] vld;
    logic [PW-1:0] ph;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Engine knobs, written only by the main sequence.
  bit          eng_silent;
  bit          eng_echo;
  int          eng_lat;
  logic [31:0] eng_val;
  logic        stray_tog;

  function automatic logic [PW-1:0] echo_of(input logic [TW-1:0] d);
    return d[63:32] ^ d[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] expv,
                            input int budget, output int waited);
    waited = 0;
    #1;
    while (req_ready == '0 && waited < budget) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check(tag, 64'(req_ready), 64'(expv));
  endtask

  task automatic wait_rsp(input string tag, input logic [NR-1:0] drop,
                          input int budget, output int n);
    bit   found;
    exp_t e;
    n = 0;
    found = 0;
    while (n < budget && !found) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = req_valid & ~drop;
      if (rsp_valid != '0) found = 1;
    end
    if (!found) begin
      n_total++;
      $error("FAIL %s_timeout: no rsp_valid within %0d cycles", tag, budget);
    end else if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s_unexpected: rsp_valid %0b with empty scoreboard", tag, rsp_valid);
    end else begin
      e = sb.pop_front();
      check({tag, "_vld"}, 64'(rsp_valid), 64'(e.vld));
      check({tag, "_phase"}, 64'(rsp_phase), 64'(e.ph));
      check({tag, "_err"}, 64'(rsp_error), 64'(e.err));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
      check({tag, "_hold"}, 64'(rsp_phase), 64'(e.ph));
    end
  endtask

  // Behavioural get_phase engine: result eng_lat cycles into WAIT.
  initial begin : engine
    bit          pending;
    int          cnt;
    logic [63:0] cap;
    logic        stray_seen;
    pending = 0; cnt = 0; cap = '0; stray_seen = 1'b0;
    m00_valid = 1'b0;
    phase = '0;
    forever begin
      @(negedge clk);
      #1;
      m00_valid = 1'b0;
      if (rst) begin
        pending = 0;
      end else begin
        if (stray_tog != stray_seen) begin
          stray_seen = stray_tog;
          m00_valid = 1'b1;
          phase = 32'hDEAD_BEEF;
        end
        if (pending) begin
          cnt++;
          if (cnt >= eng_lat) begin
            m00_valid = 1'b1;
            phase = eng_echo ? echo_of(cap) : eng_val;
            pending = 0;
          end
        end
        if (s00_valid && s00_ready && !eng_silent) begin
          pending = 1;
          cnt = 0;
          cap = phase_tdata;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] d0, d1, orig;
    logic [NR-1:0] eg;
    int lat, waited;
    d0 = 64'h7FFF0000_00007FFF;
    d1 = 64'h12345678_9ABCDEF0;
    rst = 1'b1; req_valid = '0; req_tdata = '0; s00_ready = 1'b1;
    eng_silent = 0; eng_echo = 1; eng_lat = 1; eng_val = '0; stray_tog = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s00_valid", 64'(s00_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd0);
    check("idle_tocount", 64'(timeout_count), 64'd0);
    check("idle_stray", 64'(stray_rsp), 64'd0);
    check("idle_phase_tdata", 64'(phase_tdata), 64'd0);

    // Contention: both requesters held valid, strict alternation from 0.
    req_tdata[0 +: TW] = d0;
    req_tdata[TW +: TW] = d1;
    req_valid = 2'b11;
    eng_echo = 1; eng_lat = 3;
    for (int t = 0; t < 6; t++) begin
      eg = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant("cont_grant", eg, 20, waited);
      if (t > 0) check("cont_b2b", 64'(waited), 64'd0);
      sb.push_back('{vld: eg, ph: echo_of(eg[0] ? d0 : d1), err: 1'b0});
      wait_rsp("cont_rsp", 2'b00, 40, lat);
      check("cont_lat", 64'(lat), 64'd5);
    end
    req_valid = '0;

    // Single request, engine answers 100 after 5 WAIT cycles.
    req_tdata[0 +: TW] = 64'h7FFF0000_00007FFF;
    req_valid = 2'b01;
    eng_echo = 0; eng_val = 32'd100; eng_lat = 5;
    wait_grant("single_grant", 2'b01, 20, waited);
    sb.push_back('{vld: 2'b01, ph: 32'd100, err: 1'b0});
    wait_rsp("single_rsp", 2'b01, 40, lat);
    check("single_lat", 64'(lat), 64'd7);
    check("single_tocount", 64'(timeout_count), 64'd0);

    // Silent engine: watchdog forces an error response.
    eng_silent = 1;
    req_valid = 2'b01;
    wait_grant("to_grant", 2'b01, 20, waited);
    sb.push_back('{vld: 2'b01, ph: 32'd0, err: 1'b1});
    wait_rsp("to_rsp", 2'b01, 40, lat);
    check("to_lat", 64'(lat), 64'd18);
    check("to_tocount", 64'(timeout_count), 64'd1);
    check("to_busy", 64'(busy), 64'd0);

    // Result arrives on the very cycle the watchdog would fire.
    eng_silent = 0; eng_echo = 0; eng_val = 32'h0000_1234; eng_lat = TO;
    req_valid = 2'b10;
    wait_grant("edge_grant", 2'b10, 20, waited);
    sb.push_back('{vld: 2'b10, ph: 32'h0000_1234, err: 1'b0});
    wait_rsp("edge_rsp", 2'b10, 40, lat);
    check("edge_lat", 64'(lat), 64'd18);
    check("edge_tocount", 64'(timeout_count), 64'd1);

    // Engine back-pressure: payload and valid must hold while ready is low.
    orig = 64'hA5A5_0F0F_C3C3_1E1E;
    req_tdata[TW +: TW] = orig;
    s00_ready = 1'b0;
    eng_echo = 1; eng_lat = 2;
    req_valid = 2'b10;
    wait_grant("stall_grant", 2'b10, 20, waited);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = '0;
        req_tdata = ~req_tdata;
      end
      check("stall_valid", 64'(s00_valid), 64'd1);
      check("stall_tdata", 64'(phase_tdata), orig);
      if (i == 4) s00_ready = 1'b1;
    end
    sb.push_back('{vld: 2'b10, ph: echo_of(orig), err: 1'b0});
    wait_rsp("stall_rsp", 2'b00, 40, lat);
    check("stall_lat", 64'(lat), 64'd3);
    check("stall_valid_low", 64'(s00_valid), 64'd0);

    // Stray engine result while idle.
    check("stray_pre", 64'(stray_rsp), 64'd0);
    stray_tog = ~stray_tog;
    @(negedge clk);
    @(negedge clk);
    check("stray_flag", 64'(stray_rsp), 64'd1);
    check("stray_no_rsp", 64'(rsp_valid), 64'd0);
    check("stray_phase_hold", 64'(rsp_phase), 64'(echo_of(orig)));

    // Reset while waiting on a hung engine.
    req_tdata[0 +: TW] = d0;
    eng_silent = 1;
    req_valid = 2'b01;
    wait_grant("rw_grant", 2'b01, 20, waited);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("rw_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rw_s00_valid", 64'(s00_valid), 64'd0);
    check("rw_phase_tdata", 64'(phase_tdata), 64'd0);
    check("rw_tocount", 64'(timeout_count), 64'd0);
    check("rw_stray", 64'(stray_rsp), 64'd0);
    check("rw_rsp_phase", 64'(rsp_phase), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rw_no_rsp", 64'(rsp_valid), 64'd0);
    end
    rst = 1'b0;
    eng_silent = 0; eng_echo = 1; eng_lat = 1;
    req_tdata[TW +: TW] = d1;
    req_valid = 2'b10;
    wait_grant("post_grant", 2'b10, 20, waited);
    sb.push_back('{vld: 2'b10, ph: echo_of(d1), err: 1'b0});
    wait_rsp("post_rsp", 2'b10, 40, lat);
    check("post_lat", 64'(lat), 64'd3);
    check("post_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
